// File: rtl/rx_frame_ctrl_pkg.sv
// Shared types and constants for the UART receive path.
package rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/rx_edge_bit_counter.sv
// Oversampling edge counter and bit counter; both clear whenever disabled.
module rx_edge_bit_counter
  import rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6,
  parameter int EDGE_CNT_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      i_en,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic [EDGE_CNT_WIDTH-1:0] o_edge_cnt,
  output logic [BIT_CNT_WIDTH-1:0]  o_bit_cnt,
  output logic                      o_bit_end
);

  logic [EDGE_CNT_WIDTH-1:0] r_edge_cnt;
  logic [BIT_CNT_WIDTH-1:0]  r_bit_cnt;
  logic [EDGE_CNT_WIDTH-1:0] w_last;
  logic                      w_bit_end;

  assign w_last    = EDGE_CNT_WIDTH'(i_prescale - 1'b1);
  assign w_bit_end = i_en && (r_edge_cnt == w_last);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (!i_en) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_bit_end) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= r_bit_cnt + 1'b1;
    end else begin
      r_edge_cnt <= r_edge_cnt + 1'b1;
    end
  end

  assign o_edge_cnt = r_edge_cnt;
  assign o_bit_cnt  = r_bit_cnt;
  assign o_bit_end  = w_bit_end;

endmodule

// File: rtl/rx_frame_ctrl.sv
// UART receive frame controller: start detect, bit collection, parity/stop checks.
module rx_frame_ctrl
  import rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6,
  parameter int EDGE_CNT_WIDTH = 6,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      sampled_bit,
  output logic                      data_samp_en,
  output logic [EDGE_CNT_WIDTH-1:0] edge_cnt,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam int BIT_CNT_WIDTH = $clog2(DATA_WIDTH + 4);

  rx_state_e                 r_state;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic                      r_par_bad;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic [DATA_WIDTH-1:0]     r_p_data;
  logic                      r_samp_en;
  logic                      r_data_valid;
  logic                      r_par_err;
  logic                      r_stp_err;

  logic                      w_en;
  logic                      w_bit_end;
  logic [BIT_CNT_WIDTH-1:0]  w_bit_cnt;
  logic [EDGE_CNT_WIDTH-1:0] w_edge_cnt;

  function automatic logic exp_parity(input logic [DATA_WIDTH-1:0] d, input logic typ);
    return (typ == PAR_ODD) ? ~^d : ^d;
  endfunction

  assign w_en = (r_state != IDLE);

  rx_edge_bit_counter #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH),
    .EDGE_CNT_WIDTH (EDGE_CNT_WIDTH),
    .BIT_CNT_WIDTH  (BIT_CNT_WIDTH)
  ) u_cnt (
    .CLK        (CLK),
    .RST        (RST),
    .i_en       (w_en),
    .i_prescale (r_prescale),
    .o_edge_cnt (w_edge_cnt),
    .o_bit_cnt  (w_bit_cnt),
    .o_bit_end  (w_bit_end)
  );

  // Strobes default low each cycle so they last exactly one cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= IDLE;
      r_prescale   <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_par_bad    <= 1'b0;
      r_shift      <= '0;
      r_p_data     <= '0;
      r_samp_en    <= 1'b0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          r_par_bad <= 1'b0;
          if (!RX_IN) begin
            r_prescale <= prescale;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_samp_en  <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            if (sampled_bit) begin
              r_samp_en <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_shift <= {sampled_bit, r_shift[DATA_WIDTH-1:1]};
            if (w_bit_cnt == BIT_CNT_WIDTH'(DATA_WIDTH))
              r_state <= r_par_en ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_par_bad <= (sampled_bit != exp_parity(r_shift, r_par_typ));
            r_state   <= STOP;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            if (!r_par_bad && sampled_bit) begin
              r_data_valid <= 1'b1;
              r_p_data     <= r_shift;
            end
            r_par_err <= r_par_bad;
            r_stp_err <= !sampled_bit;
            r_samp_en <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_samp_en <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign data_samp_en = r_samp_en;
  assign edge_cnt     = w_edge_cnt;
  assign P_DATA       = r_p_data;
  assign data_valid   = r_data_valid;
  assign par_err      = r_par_err;
  assign stp_err      = r_stp_err;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl: directed frames, strobe monitor on negedge.
module tb_rx_frame_ctrl;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] prescale;
  logic       sampled_bit;
  logic       data_samp_en;
  logic [5:0] edge_cnt;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic       v;
    logic       pe;
    logic       se;
    logic [7:0] d;
    int         at;
  } exp_t;

  exp_t q[$];

  rx_frame_ctrl #(
    .PRESCALE_WIDTH (6),
    .EDGE_CNT_WIDTH (6),
    .DATA_WIDTH     (8)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .prescale     (prescale),
    .sampled_bit  (sampled_bit),
    .data_samp_en (data_samp_en),
    .edge_cnt     (edge_cnt),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .par_err      (par_err),
    .stp_err      (stp_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe cycle must match the head of the expectation queue.
  always @(negedge CLK) begin
    if (RST && (data_valid || par_err || stp_err)) begin
      if (q.size() == 0) begin
        check("unexpected_strobe", 32'({data_valid, par_err, stp_err}), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("data_valid", 32'(data_valid), 32'(e.v));
        check("par_err",    32'(par_err),    32'(e.pe));
        check("stp_err",    32'(stp_err),    32'(e.se));
        check("P_DATA",     32'(P_DATA),     32'(e.d));
        check("strobe_cycle", 32'(cyc),      32'(e.at));
      end
    end
  end

  // Drives one frame cycle by cycle. RX_IN follows the serial bits from cycle t;
  // sampled_bit presents the bit the DUT is currently inside (offset by one cycle).
  // Configuration inputs are scrambled after the start edge to prove they are latched.
  task automatic send_frame(input logic [7:0] data, input int p, input bit pen, input bit ptyp,
                            input bit pbit, input bit sbit, input bit ev, input bit epe,
                            input bit ese, input logic [7:0] ed, input int lat, input int abort_at);
    logic bits [0:10];
    int   n;
    int   t;
    exp_t e;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    n = 9;
    if (pen) begin
      bits[9] = pbit;
      n = 10;
    end
    bits[n] = sbit;
    n = n + 1;
    t = cyc;
    if (abort_at < 0) begin
      e.v = ev; e.pe = epe; e.se = ese; e.d = ed; e.at = t + lat;
      q.push_back(e);
    end
    prescale = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    for (int c = 0; c <= n * p; c++) begin
      if (c == abort_at) return;
      RX_IN       = (c < n * p) ? bits[c / p] : 1'b1;
      sampled_bit = (c == 0) ? 1'b1 : bits[(c - 1) / p];
      if (c == 1) begin
        prescale = (p == 8) ? 6'd16 : 6'd8;
        PAR_EN   = ~pen;
        PAR_TYP  = ~ptyp;
      end
      @(posedge CLK); #1;
      if (c == 0) begin
        check("start_samp_en",  32'(data_samp_en), 1);
        check("start_edge_cnt", 32'(edge_cnt),     0);
      end
    end
    check("strobe_samp_en_low", 32'(data_samp_en), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    prescale = 6'd8; sampled_bit = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_data_valid", 32'(data_valid),   0);
    check("rst_par_err",    32'(par_err),      0);
    check("rst_stp_err",    32'(stp_err),      0);
    check("rst_P_DATA",     32'(P_DATA),       0);
    check("rst_samp_en",    32'(data_samp_en), 0);
    check("rst_edge_cnt",   32'(edge_cnt),     0);
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;

    // Basic, stop error, good/bad parity, both errors
    send_frame(8'hA5, 8,  0, 0, 0, 1, 1, 0, 0, 8'hA5, 81,  -1);
    send_frame(8'h77, 8,  0, 0, 0, 0, 0, 0, 1, 8'hA5, 81,  -1);
    send_frame(8'h3C, 16, 1, 0, 0, 1, 1, 0, 0, 8'h3C, 177, -1);
    send_frame(8'h3C, 16, 1, 0, 1, 1, 0, 1, 0, 8'h3C, 177, -1);
    send_frame(8'h81, 8,  1, 0, 1, 0, 0, 1, 1, 8'h3C, 89,  -1);
    repeat (3) @(posedge CLK);
    #1;

    // Start glitch: line low for two cycles only
    t = cyc;
    prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      RX_IN = (c < 2) ? 1'b0 : 1'b1;
      sampled_bit = 1'b1;
      @(posedge CLK); #1;
      if (c == 6) check("glitch_start_samp_en", 32'(data_samp_en), 1);
    end
    check("glitch_cycle",        32'(cyc),          32'(t + 9));
    check("glitch_samp_en_low",  32'(data_samp_en), 0);
    check("glitch_edge_cnt",     32'(edge_cnt),     0);
    repeat (4) @(posedge CLK);
    #1;

    // Back-to-back, odd parity, second start in the strobe cycle
    send_frame(8'h00, 32, 1, 1, 1, 1, 1, 0, 0, 8'h00, 353, -1);
    send_frame(8'hFF, 32, 1, 1, 1, 1, 1, 0, 0, 8'hFF, 353, -1);
    repeat (3) @(posedge CLK);
    #1;

    // Reset in the middle of the data bits
    send_frame(8'hC3, 8, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 40);
    check("mid_samp_en",  32'(data_samp_en), 1);
    check("mid_edge_cnt", 32'(edge_cnt),     7);
    #2;
    RST = 1'b0;
    #1;
    check("midrst_P_DATA",   32'(P_DATA),       0);
    check("midrst_samp_en",  32'(data_samp_en), 0);
    check("midrst_edge_cnt", 32'(edge_cnt),     0);
    check("midrst_strobes",  32'({data_valid, par_err, stp_err}), 0);
    RX_IN = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    send_frame(8'h5A, 8, 0, 0, 0, 1, 1, 0, 0, 8'h5A, 81, -1);

    repeat (6) @(posedge CLK);
    #1;
    check("pending_expectations", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
